// File: rtl/gray_if.sv
// ============================================================================
// Module      : gray_if
// Description : Sample/result bundle for the gray code converter.
//               master : producer of samples (drives in_valid, A, use_gray)
//               slave  : converter (drives B, out_valid)
// Signals     : in_valid  - A/use_gray valid this cycle
//               A         - binary input code, IN_W bits
//               use_gray  - 1: Gray conversion, 0: position code
//               B         - registered converted code, OUT_W bits
//               out_valid - B holds a result from a sampled input
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2**IN_W-1
);
  logic             in_valid;
  logic [IN_W-1:0]  A;
  logic             use_gray;
  logic [OUT_W-1:0] B;
  logic             out_valid;

  modport master (
    output in_valid,
    output A,
    output use_gray,
    input  B,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  A,
    input  use_gray,
    output B,
    output out_valid
  );
endinterface : gray_if

`default_nettype wire

// File: rtl/gray.sv
// ============================================================================
// Module      : gray
// Description : Registered binary-to-code converter. Each accepted sample is
//               converted to either its reflected Gray code (zero-extended)
//               or a one-hot position code (A=0 -> 0, A=k -> bit k-1 set).
//               One cycle latency, one sample per clock, no back-pressure.
// Ports       : clk   - system clock, rising edge active
//               rst_n - asynchronous reset, active low
//               bus   - gray_if.slave (in_valid, A, use_gray -> B, out_valid)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2**IN_W-1
) (
  input  wire   clk,
  input  wire   rst_n,
  gray_if.slave bus
);

  logic [OUT_W-1:0] w_b;
  logic [OUT_W-1:0] r_b;
  logic             r_out_valid;

  // Pure conversion function f(A, use_gray).
  always_comb begin
    w_b = '0;
    if (bus.use_gray) begin
      w_b[IN_W-1:0] = bus.A ^ (bus.A >> 1);
    end else begin
      // Decode A=k to bit k-1; A=0 matches no k and leaves all zero.
      for (int k = 1; k <= OUT_W; k++) begin
        if (bus.A == IN_W'(k)) begin
          w_b[k-1] = 1'b1;
        end
      end
    end
  end

  // B only loads on accepted samples, so A while in_valid=0 cannot reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b         <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      r_b         <= w_b;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.B         = r_b;
  assign bus.out_valid = r_out_valid;

endmodule : gray

`default_nettype wire

// File: tb/tb_gray.sv
// ============================================================================
// Module      : tb_gray
// Description : Self-checking bench for gray: directed reset, sweeps, mode
//               toggle and hold cases, then randomized samples compared with
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray;
  localparam int IN_W  = 3;
  localparam int OUT_W = 2**IN_W-1;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  logic [OUT_W-1:0] exp_b;
  logic             exp_v;

  gray_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gray #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: conversion from plain arithmetic on the integer value.
  function automatic logic [OUT_W-1:0] ref_f(input int a, input bit g);
    int r;
    if (g) r = a ^ (a / 2);
    else   r = (a == 0) ? 0 : (1 << (a - 1));
    return OUT_W'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of stimulus, then check B/out_valid after the edge.
  task automatic step(input bit v, input int a, input bit g, input string tag);
    @(negedge clk);
    bus.in_valid = v;
    bus.A        = IN_W'(a);
    bus.use_gray = g;
    @(posedge clk);
    #1;
    if (v) begin
      exp_b = ref_f(a, g);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    chk({tag, "_B"}, 32'(bus.B), 32'(exp_b));
    chk({tag, "_V"}, 32'(bus.out_valid), 32'(exp_v));
  endtask

  logic [7:0] gray_tab [8];
  logic [7:0] pos_tab  [8];

  initial begin
    gray_tab = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
    pos_tab  = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    n_vec = 0;
    n_err = 0;
    exp_b = '0;
    exp_v = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.use_gray = 1'b0;

    #2;
    chk("rst_B", 32'(bus.B), 32'h0);
    chk("rst_V", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Gray sweep against the fixed table.
    for (int a = 0; a < 8; a++) begin
      step(1'b1, a, 1'b1, "gray");
      chk("gray_tab", 32'(bus.B), 32'(gray_tab[a]));
    end

    // Position sweep against the fixed table.
    for (int a = 0; a < 8; a++) begin
      step(1'b1, a, 1'b0, "pos");
      chk("pos_tab", 32'(bus.B), 32'(pos_tab[a]));
    end

    // Mode toggle on the same A.
    step(1'b1, 7, 1'b1, "tog_g");
    chk("tog_g_lit", 32'(bus.B), 32'h04);
    step(1'b1, 7, 1'b0, "tog_p");
    chk("tog_p_lit", 32'(bus.B), 32'h40);

    // Asynchronous reset mid-cycle with B=1000000.
    @(negedge clk);
    bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_B", 32'(bus.B), 32'h0);
    chk("arst_V", 32'(bus.out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_B", 32'(bus.B), 32'h0);
    exp_b = '0;
    exp_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Hold: load A=5 position, then idle with a different A and with X.
    step(1'b1, 5, 1'b0, "ld5");
    chk("ld5_lit", 32'(bus.B), 32'h10);
    step(1'b0, 3, 1'b1, "hold");
    chk("hold_lit", 32'(bus.B), 32'h10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = 'x;
    @(posedge clk);
    #1;
    chk("holdx_B", 32'(bus.B), 32'h10);
    chk("holdx_V", 32'(bus.out_valid), 32'h0);

    // Randomized samples.
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_gray

`default_nettype wire
